// File: rtl/q_learning_sequencer.sv
// q_learning_sequencer
//   Step controller for the Q-learning accelerator. Each iteration walks
//   FETCH -> WAIT_Q -> DECIDE -> ENV -> UPDATE -> NEXT, then either loops
//   back to FETCH or stops in DONE once `iteration` reaches the latched
//   budget. Episodes restart from the latched start state on a terminal
//   next state or after MAX_STEPS steps.
//
// Ports
//   clk, rst            clock, async active-high reset
//   start               run request (accepted in IDLE/DONE only)
//   total_iteration_in  iteration budget, latched on accepted start
//   start_state         episode start state, latched on accepted start
//   q_rd_en/q_rd_addr   one-cycle Q-row read request, row = cur_state
//   q_rd_valid          Q row ready at the action determiner
//   ad_en / act         action determiner window / chosen action
//   iteration           completed updates this run
//   total_iteration     latched budget
//   env_req/env_state/env_act, env_ack/env_next_state/env_terminal
//                       environment step handshake
//   upd_en / upd_done   Q-update trigger / completion
//   cur_state, episode  current state, completed episodes
//   busy, done          running flag, one-cycle completion pulse
module q_learning_sequencer #(
  parameter int STATE_W   = 4,
  parameter int ITER_W    = 12,
  parameter int AD_LAT    = 1,
  parameter int MAX_STEPS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ITER_W-1:0]  total_iteration_in,
  input  logic [STATE_W-1:0] start_state,
  output logic               q_rd_en,
  output logic [STATE_W-1:0] q_rd_addr,
  input  logic               q_rd_valid,
  output logic               ad_en,
  input  logic [1:0]         act,
  output logic [ITER_W-1:0]  iteration,
  output logic [ITER_W-1:0]  total_iteration,
  output logic               env_req,
  output logic [STATE_W-1:0] env_state,
  output logic [1:0]         env_act,
  input  logic               env_ack,
  input  logic [STATE_W-1:0] env_next_state,
  input  logic               env_terminal,
  output logic               upd_en,
  input  logic               upd_done,
  output logic [STATE_W-1:0] cur_state,
  output logic [15:0]        episode,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT_Q = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_ENV    = 3'd4;
  localparam logic [2:0] S_UPDATE = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]         state;
  logic [AD_LAT:0]    vld_pipe;     // one-hot position inside the ad_en window
  logic [15:0]        step_cnt;
  logic [STATE_W-1:0] start_state_q;
  logic [STATE_W-1:0] nxt_state_q;
  logic               term_q;

  logic [ITER_W-1:0]  iter_inc;
  logic [15:0]        step_inc;
  logic               ep_end;

  assign iter_inc = iteration + ITER_W'(1);
  assign step_inc = step_cnt + 16'd1;
  assign ep_end   = term_q || (step_inc == 16'(MAX_STEPS));

  // Both views of the current state come straight from the cur_state flop.
  assign q_rd_addr = cur_state;
  assign env_state = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      vld_pipe        <= '0;
      step_cnt        <= '0;
      start_state_q   <= '0;
      nxt_state_q     <= '0;
      term_q          <= 1'b0;
      q_rd_en         <= 1'b0;
      ad_en           <= 1'b0;
      iteration       <= '0;
      total_iteration <= '0;
      env_req         <= 1'b0;
      env_act         <= '0;
      upd_en          <= 1'b0;
      cur_state       <= '0;
      episode         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      // single-cycle strobes
      q_rd_en <= 1'b0;
      upd_en  <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            total_iteration <= total_iteration_in;
            start_state_q   <= start_state;
            cur_state       <= start_state;
            iteration       <= '0;
            step_cnt        <= '0;
            episode         <= '0;
            if (total_iteration_in == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= S_FETCH;
              q_rd_en <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        S_FETCH: state <= S_WAIT_Q;
        S_WAIT_Q: begin
          if (q_rd_valid) begin
            state    <= S_DECIDE;
            ad_en    <= 1'b1;
            vld_pipe <= (AD_LAT+1)'(1);
          end
        end
        S_DECIDE: begin
          // act is trusted only after AD_LAT cycles of ad_en
          if (vld_pipe[AD_LAT]) begin
            env_act  <= act;
            ad_en    <= 1'b0;
            env_req  <= 1'b1;
            vld_pipe <= '0;
            state    <= S_ENV;
          end else begin
            vld_pipe <= vld_pipe << 1;
          end
        end
        S_ENV: begin
          if (env_ack) begin
            env_req     <= 1'b0;
            nxt_state_q <= env_next_state;
            term_q      <= env_terminal;
            upd_en      <= 1'b1;
            state       <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          // upd_done may coincide with the upd_en cycle
          if (upd_done) state <= S_NEXT;
        end
        S_NEXT: begin
          iteration <= iter_inc;
          if (ep_end) begin
            episode   <= episode + 16'd1;
            step_cnt  <= '0;
            cur_state <= start_state_q;
          end else begin
            step_cnt  <= step_inc;
            cur_state <= nxt_state_q;
          end
          if (iter_inc == total_iteration) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= S_FETCH;
            q_rd_en <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_learning_sequencer.sv
// Bench for q_learning_sequencer: negedge responders with random latencies,
// plus a transaction-level model (episode/step bookkeeping per completed
// environment step) that predicts cur_state, episode, iteration, busy, done.
module tb_q_learning_sequencer;
  localparam int SW = 4, IW = 12, ADL = 1, MAXS = 4;

  logic clk, rst, start;
  logic [IW-1:0] total_iteration_in, iteration, total_iteration;
  logic [SW-1:0] start_state, q_rd_addr, env_state, env_next_state, cur_state;
  logic q_rd_en, q_rd_valid, ad_en, env_req, env_ack, env_terminal, upd_en, upd_done, busy, done;
  logic [1:0] act, env_act;
  logic [15:0] episode;
  logic [59:0] outs;

  assign outs = {q_rd_en, q_rd_addr, ad_en, iteration, total_iteration, env_req, env_state,
                 env_act, upd_en, cur_state, episode, busy, done};

  q_learning_sequencer #(.STATE_W(SW), .ITER_W(IW), .AD_LAT(ADL), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst(rst), .start(start), .total_iteration_in(total_iteration_in),
    .start_state(start_state), .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_valid(q_rd_valid),
    .ad_en(ad_en), .act(act), .iteration(iteration), .total_iteration(total_iteration),
    .env_req(env_req), .env_state(env_state), .env_act(env_act), .env_ack(env_ack),
    .env_next_state(env_next_state), .env_terminal(env_terminal), .upd_en(upd_en),
    .upd_done(upd_done), .cur_state(cur_state), .episode(episode), .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // responder configuration
  bit zero_wait = 0, rnd_dly = 0, noise = 0, stray_upd = 0;
  int env_dly = 0, term_mode = 0, term_at = 0;

  // model and monitor state
  bit m_run = 0, start_pend = 0, hs_pend = 0, hs_term = 0, exp_done;
  int m_total = 0, m_sstate = 0, m_state = 0, m_step = 0, m_ep = 0, m_iter = 0, hs_next = 0;
  int p_total, p_ss, run_hs = 0, start_cyc = 0, last_iter_cyc = 0;
  int done_cnt = 0, upd_cnt = 0, qrd_cnt = 0, adlen = 0, envlen = 0, cur_env_dly = 0;
  bit prev_qrd = 0, prev_upd = 0, prev_envreq = 0;
  logic [1:0] act_cap = 0, prev_env_act = 0;
  bit q_act = 0, e_act = 0, u_act = 0;
  int q_cnt = 0, e_cnt = 0, u_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_outs", 64'(outs), 64'd0);
      m_run = 0; start_pend = 0; hs_pend = 0; m_total = 0; m_sstate = 0; m_state = 0;
      m_step = 0; m_ep = 0; m_iter = 0; adlen = 0; envlen = 0;
      prev_qrd = 0; prev_upd = 0; prev_envreq = 0; q_act = 0; e_act = 0; u_act = 0;
      q_rd_valid = 0; env_ack = 0; upd_done = 0; env_terminal = 0;
    end else begin
      exp_done = 0;
      if (start_pend) begin
        start_pend = 0; m_total = p_total; m_sstate = p_ss; m_state = p_ss;
        m_iter = 0; m_ep = 0; m_step = 0; hs_pend = 0; run_hs = 0; qrd_cnt = 0; upd_cnt = 0;
        start_cyc = cyc; last_iter_cyc = cyc;
        if (p_total == 0) exp_done = 1; else m_run = 1;
      end
      if (iteration != IW'(m_iter)) begin
        chk("iter_inc", 64'(iteration), 64'(m_iter + 1));
        chk("hs_before_inc", 64'(hs_pend), 64'd1);
        m_step++;
        if (hs_term || m_step == MAXS) begin
          m_ep = (m_ep + 1) % 65536; m_step = 0; m_state = m_sstate;
        end else m_state = hs_next;
        hs_pend = 0;
        m_iter++;
        if (zero_wait) chk("iter_period", 64'(cyc - last_iter_cyc), 64'd7);
        last_iter_cyc = cyc;
        if (m_iter == m_total) begin exp_done = 1; m_run = 0; end
      end
      if (exp_done && zero_wait) chk("done_cyc", 64'(cyc - start_cyc), 64'(7 * m_total));
      chk("cur_state", 64'(cur_state), 64'(m_state));
      chk("env_state", 64'(env_state), 64'(m_state));
      chk("q_rd_addr", 64'(q_rd_addr), 64'(m_state));
      chk("episode", 64'(episode), 64'(m_ep));
      chk("iteration", 64'(iteration), 64'(m_iter));
      chk("total_iter", 64'(total_iteration), 64'(m_total));
      chk("done", 64'(done), 64'(exp_done));
      chk("busy", 64'(busy), 64'(m_run));
      if (done) done_cnt++;
      if (q_rd_en) begin
        qrd_cnt++;
        chk("qrd_pulse", 64'(prev_qrd), 64'd0);
        chk("qrd_in_run", 64'(m_run), 64'd1);
      end
      if (upd_en) begin
        upd_cnt++;
        chk("upd_pulse", 64'(prev_upd), 64'd0);
      end
      if (ad_en) adlen++;
      else if (adlen != 0) begin chk("ad_len", 64'(adlen), 64'(ADL + 1)); adlen = 0; end
      if (env_req) begin
        envlen++;
        if (!prev_envreq) chk("env_act", 64'(env_act), 64'(act_cap));
        else chk("env_act_hold", 64'(env_act), 64'(prev_env_act));
      end else if (envlen != 0) begin
        chk("env_len", 64'(envlen), 64'(cur_env_dly + 1)); envlen = 0;
      end
      if (start && !m_run) begin start_pend = 1; p_total = int'(total_iteration_in); p_ss = int'(start_state); end

      // responders: values driven here are sampled at the next posedge
      act = 2'($urandom);
      if (ad_en) act_cap = act;
      if (q_rd_en) begin
        q_act = 1; q_cnt = rnd_dly ? $urandom_range(0, 3) : 0; q_rd_valid = 0;
      end else if (q_act) begin
        if (q_cnt == 0) begin q_rd_valid = 1; q_act = 0; end
        else begin q_cnt--; q_rd_valid = 0; end
      end else q_rd_valid = 0;
      env_next_state = SW'($urandom);
      if (env_req) begin
        if (!e_act) begin
          e_act = 1; e_cnt = rnd_dly ? $urandom_range(0, 4) : env_dly; cur_env_dly = e_cnt;
        end
        if (e_cnt == 0) begin
          env_ack = 1; run_hs++;
          case (term_mode)
            1: env_terminal = (run_hs == term_at);
            2: env_terminal = ($urandom_range(0, 7) == 0);
            default: env_terminal = 0;
          endcase
          hs_pend = 1; hs_next = int'(env_next_state); hs_term = env_terminal;
        end else begin
          env_ack = 0; e_cnt--; env_terminal = 1'($urandom);
        end
      end else begin
        e_act = 0; env_ack = noise ? 1'($urandom) : 1'b0; env_terminal = 1'($urandom);
      end
      if (upd_en) begin u_act = 1; u_cnt = rnd_dly ? $urandom_range(0, 3) : 0; end
      if (u_act) begin
        if (u_cnt == 0) begin upd_done = 1; u_act = 0; end
        else begin u_cnt--; upd_done = 0; end
      end else upd_done = stray_upd && env_req;
      prev_qrd = q_rd_en; prev_upd = upd_en; prev_envreq = env_req; prev_env_act = env_act;
    end
  end

  task automatic pulse_start(input int budget, input int ss);
    @(posedge clk); #1;
    total_iteration_in = IW'(budget); start_state = SW'(ss); start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run(input int budget, input int ss, input int lim, input bit poke);
    int d0;
    bit ok;
    d0 = done_cnt; ok = 0;
    pulse_start(budget, ss);
    if (poke) begin repeat (3) @(posedge clk); pulse_start(9, 1); end
    for (int i = 0; i < lim; i++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("done_seen", 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, uc;
    bit ok;
    rst = 1; start = 0; total_iteration_in = 0; start_state = 0; act = 0;
    q_rd_valid = 0; env_ack = 0; env_next_state = 0; env_terminal = 0; upd_done = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (20) begin @(posedge clk); #1; chk("idle_outs", 64'(outs), 64'd0); end

    // zero-wait responders, budget 3 from state 2
    zero_wait = 1; d0 = done_cnt;
    run(3, 2, 200, 0);
    repeat (5) @(posedge clk); #1;
    chk("t2_iter", 64'(iteration), 64'd3);
    chk("t2_upd_cnt", 64'(upd_cnt), 64'd3);
    chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
    zero_wait = 0;

    // terminal on the 2nd step
    term_mode = 1; term_at = 2;
    run(3, 5, 300, 0);
    chk("caseA_episode", 64'(episode), 64'd1);
    term_mode = 0;

    // step limit only
    run(10, 9, 500, 0);
    chk("caseB_episode", 64'(episode), 64'd2);
    chk("caseB_iter", 64'(iteration), 64'd10);

    // stalling environment with stray upd_done
    env_dly = 5; stray_upd = 1;
    run(2, 3, 300, 0);
    chk("stall_upd_cnt", 64'(upd_cnt), 64'd2);
    env_dly = 0; stray_upd = 0;

    // zero budget, then restart from DONE with a stray start while busy
    d0 = done_cnt;
    pulse_start(0, 7);
    chk("zb_done", 64'(done), 64'd1);
    chk("zb_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("zb_qrd_cnt", 64'(qrd_cnt), 64'd0);
    chk("zb_done_cnt", 64'(done_cnt - d0), 64'd1);
    run(2, 6, 300, 1);
    chk("restart_iter", 64'(iteration), 64'd2);
    chk("restart_total", 64'(total_iteration), 64'd2);
    chk("restart_upd_cnt", 64'(upd_cnt), 64'd2);

    // randomized runs
    rnd_dly = 1; noise = 1; term_mode = 2;
    for (int r = 0; r < 10; r++) run($urandom_range(1, 12), $urandom_range(0, 15), 2000, 0);
    rnd_dly = 0; noise = 0; term_mode = 0;

    // reset during UPDATE
    pulse_start(5, 4);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (upd_en) begin ok = 1; break; end
    end
    chk("mid_upd_seen", 64'(ok), 64'd1);
    #2 rst = 1;
    #1 chk("async_rst_outs", 64'(outs), 64'd0);
    uc = upd_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (10) @(posedge clk);
    #1 chk("no_upd_repeat", 64'(upd_cnt), 64'(uc));
    chk("post_rst_outs", 64'(outs), 64'd0);
    run(2, 1, 300, 0);
    chk("post_rst_iter", 64'(iteration), 64'd2);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
